// File: rtl/seg7_scan_driver_pkg.sv
// Shared types and the hex-to-segment table for the 4-digit 7-segment scan driver.
package seg7_pkg;

   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned DIGIT_W    = 4;
   localparam int unsigned SEG_W      = 7;

   localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      ON    = 2'd2
   } seg7_state_t;

   typedef struct packed {
      logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits;
      logic [NUM_DIGITS-1:0]              dp;
   } seg7_frame_t;

   // Active-low {g,f,e,d,c,b,a} pattern for one hex digit
   function automatic logic [SEG_W-1:0] hex_to_seg(input logic [DIGIT_W-1:0] hex);
      logic [SEG_W-1:0] seg;
      case (hex)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         default: seg = 7'b0001110;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Controller display_out bus feeding the scan driver.
interface seg7_scan_driver_if;
   logic [3:0][3:0] digits_in;
   logic [3:0]      dp_in;
   logic            digits_valid;
   logic [2:0]      brightness;
   logic            enable;

   modport master (output digits_in, dp_in, digits_valid, brightness, enable);
   modport slave  (input  digits_in, dp_in, digits_valid, brightness, enable);
endinterface

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// Combinational hex digit to active-low 7-segment decoder.
module hex_to_seg7
   import seg7_pkg::*;
(
   input  logic [DIGIT_W-1:0] hex,
   output logic [SEG_W-1:0]   seg_c
);
   assign seg_c = hex_to_seg(hex);
endmodule

// File: rtl/seg7_scan_driver.sv
// Latches digits from the controller bus and time-multiplexes a 4-digit
// common-anode display with per-slot blanking and 8-level PWM brightness.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int unsigned REFRESH_DIV  = 50000,
   parameter int unsigned BLANK_CYCLES = 16
)(
   input  logic                  clk,
   input  logic                  reset,
   seg7_scan_driver_if.slave     bus,
   output logic [NUM_DIGITS-1:0] anode_n,
   output logic [SEG_W-1:0]      seg_n,
   output logic                  dp_n,
   output logic                  frame_done
);

   localparam int unsigned ON_LEN = REFRESH_DIV - BLANK_CYCLES;
   localparam int unsigned SUB    = ON_LEN / 8;
   localparam int unsigned CNT_W  = $clog2(REFRESH_DIV);

   if ((REFRESH_DIV <= BLANK_CYCLES) || (((REFRESH_DIV - BLANK_CYCLES) % 8) != 0)) begin : g_param_check
      $error("seg7_scan_driver: REFRESH_DIV-BLANK_CYCLES must be positive and a multiple of 8");
   end

   seg7_state_t         state_q, state_d;
   logic [1:0]          idx_q, idx_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   seg7_frame_t         pend_q, pend_d, act_q, act_d;
   logic                pend_flag_q, pend_flag_d;
   logic                frame_done_d;
   logic [3:0]          anode_d;
   logic [SEG_W-1:0]    seg_d, dec_seg;
   logic                dp_d, lit;
   logic [DIGIT_W-1:0]  digit_sel;

   // State and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         idx_q       <= 2'd0;
         cnt_q       <= '0;
         pend_q      <= '0;
         act_q       <= '0;
         pend_flag_q <= 1'b0;
         anode_n     <= 4'hF;
         seg_n       <= SEG_OFF;
         dp_n        <= 1'b1;
         frame_done  <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         pend_q      <= pend_d;
         act_q       <= act_d;
         pend_flag_q <= pend_flag_d;
         anode_n     <= anode_d;
         seg_n       <= seg_d;
         dp_n        <= dp_d;
         frame_done  <= frame_done_d;
      end
   end

   // Next-state, counters, pending capture and frame-boundary commit
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      pend_d       = pend_q;
      pend_flag_d  = pend_flag_q;
      act_d        = act_q;
      frame_done_d = 1'b0;

      if (bus.digits_valid) begin
         pend_d.digits = bus.digits_in;
         pend_d.dp     = bus.dp_in;
         pend_flag_d   = 1'b1;
      end

      if (!bus.enable) begin
         state_d = IDLE;
         idx_d   = 2'd0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = BLANK;
               idx_d   = 2'd0;
               cnt_d   = '0;
            end
            BLANK: begin
               if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
                  state_d = ON;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ON: begin
               if (cnt_q == CNT_W'(ON_LEN - 1)) begin
                  state_d = BLANK;
                  cnt_d   = '0;
                  idx_d   = idx_q + 2'd1;
                  if (idx_q == 2'd3) begin
                     frame_done_d = 1'b1;
                     // pend_d already carries a same-cycle strobe (bypass)
                     if (pend_flag_q || bus.digits_valid) act_d = pend_d;
                     pend_flag_d = 1'b0;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign digit_sel = act_q.digits[idx_d];

   hex_to_seg7 u_dec (
      .hex   (digit_sel),
      .seg_c (dec_seg)
   );

   // Pin values for the upcoming cycle, registered above
   always_comb begin
      anode_d = 4'hF;
      seg_d   = SEG_OFF;
      dp_d    = 1'b1;
      lit     = (32'(cnt_d) < (32'(bus.brightness) + 32'd1) * SUB);
      if (state_d == ON) begin
         anode_d = ~(4'b0001 << idx_d);
         if (lit) begin
            seg_d = dec_seg;
            dp_d  = ~act_q.dp[idx_d];
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver (REFRESH_DIV=20, BLANK_CYCLES=4).
module tb_seg7_scan_driver;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] anode_n;
   logic [6:0] seg_n;
   logic       dp_n;
   logic       frame_done;

   seg7_scan_driver_if bus();

   seg7_scan_driver #(.REFRESH_DIV(20), .BLANK_CYCLES(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .anode_n    (anode_n),
      .seg_n      (seg_n),
      .dp_n       (dp_n),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [3:0] anode;
      logic [6:0] seg;
      logic       dp;
      logic       fd;
   } vec_t;

   vec_t tbl[16];
   int   cyc;
   int   n_chk;
   int   n_pass;
   int   n_lit;
   int   n_an;

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic goto(input int n);
      while (cyc < n) step();
   endtask

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, got, exp);
   endtask

   task automatic chk_out(input string name, input logic [3:0] a, input logic [6:0] s,
                          input logic d, input logic f);
      chk(name, {3'b000, anode_n, seg_n, dp_n, frame_done}, {3'b000, a, s, d, f});
   endtask

   task automatic strobe(input logic [15:0] dg, input logic [3:0] dp);
      bus.digits_in    = dg;
      bus.dp_in        = dp;
      bus.digits_valid = 1'b1;
      step();
      bus.digits_valid = 1'b0;
   endtask

   initial begin
      cyc = 0; n_chk = 0; n_pass = 0;
      bus.digits_in = '0; bus.dp_in = '0; bus.digits_valid = 1'b0;
      bus.brightness = 3'd7; bus.enable = 1'b0;

      // reset asserts outputs dark without any clock edge
      reset = 1'b1;
      #1 reset = 1'b0;
      #1 chk_out("reset_async", 4'hF, 7'h7F, 1'b1, 1'b0);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      cyc = 0;

      // first frame shows cleared active digits; strobed digits appear after commit
      tbl[0]  = '{1,   4'hF,    7'h7F, 1'b1, 1'b0};
      tbl[1]  = '{4,   4'hF,    7'h7F, 1'b1, 1'b0};
      tbl[2]  = '{5,   4'b1110, 7'h40, 1'b1, 1'b0};
      tbl[3]  = '{20,  4'b1110, 7'h40, 1'b1, 1'b0};
      tbl[4]  = '{21,  4'hF,    7'h7F, 1'b1, 1'b0};
      tbl[5]  = '{25,  4'b1101, 7'h40, 1'b1, 1'b0};
      tbl[6]  = '{81,  4'hF,    7'h7F, 1'b1, 1'b1};
      tbl[7]  = '{82,  4'hF,    7'h7F, 1'b1, 1'b0};
      tbl[8]  = '{84,  4'hF,    7'h7F, 1'b1, 1'b0};
      tbl[9]  = '{85,  4'b1110, 7'h00, 1'b1, 1'b0};
      tbl[10] = '{100, 4'b1110, 7'h00, 1'b1, 1'b0};
      tbl[11] = '{101, 4'hF,    7'h7F, 1'b1, 1'b0};
      tbl[12] = '{105, 4'b1101, 7'h40, 1'b0, 1'b0};
      tbl[13] = '{125, 4'b1011, 7'h79, 1'b1, 1'b0};
      tbl[14] = '{145, 4'b0111, 7'h0E, 1'b1, 1'b0};
      tbl[15] = '{161, 4'hF,    7'h7F, 1'b1, 1'b1};

      bus.enable = 1'b1;
      strobe(16'hF108, 4'b0010);
      for (int i = 0; i < 16; i++) begin
         goto(tbl[i].cyc);
         chk_out($sformatf("frame_vec%0d", i), tbl[i].anode, tbl[i].seg, tbl[i].dp, tbl[i].fd);
      end

      // mid-frame strobes: old digits until frame end, last strobe wins
      goto(170); strobe(16'hABCD, 4'b0000);
      goto(190); strobe(16'h9765, 4'b1000);
      goto(205); chk_out("midframe_old_d2", 4'b1011, 7'h79, 1'b1, 1'b0);
      goto(225); chk_out("midframe_old_d3", 4'b0111, 7'h0E, 1'b1, 1'b0);
      goto(241); chk_out("midframe_commit", 4'hF, 7'h7F, 1'b1, 1'b1);
      goto(245); chk_out("last_wins_d0", 4'b1110, 7'h12, 1'b1, 1'b0);
      goto(265); chk_out("last_wins_d1", 4'b1101, 7'h02, 1'b1, 1'b0);
      goto(285); chk_out("last_wins_d2", 4'b1011, 7'h78, 1'b1, 1'b0);
      goto(305); chk_out("last_wins_d3", 4'b0111, 7'h10, 1'b0, 1'b0);

      // strobe on the commit cycle itself is taken directly
      goto(320); strobe(16'hE432, 4'b0000);
      chk_out("bypass_fd", 4'hF, 7'h7F, 1'b1, 1'b1);
      goto(325); chk_out("bypass_d0", 4'b1110, 7'h24, 1'b1, 1'b0);
      goto(345); chk_out("bypass_d1", 4'b1101, 7'h30, 1'b1, 1'b0);

      // PWM duty at brightness 0 and 3
      goto(360); bus.brightness = 3'd0;
      n_lit = 0; n_an = 0;
      for (int i = 0; i < 16; i++) begin
         goto(365 + i);
         if (seg_n != 7'h7F) n_lit++;
         if (anode_n == 4'b1011) n_an++;
         if (i == 1) chk_out("bright0_last_lit", 4'b1011, 7'h19, 1'b1, 1'b0);
         if (i == 2) chk_out("bright0_first_dark", 4'b1011, 7'h7F, 1'b1, 1'b0);
      end
      chk("bright0_lit_cycles", 16'(n_lit), 16'd2);
      chk("bright0_anode_cycles", 16'(n_an), 16'd16);
      bus.brightness = 3'd3;
      n_lit = 0; n_an = 0;
      for (int i = 0; i < 16; i++) begin
         goto(385 + i);
         if (seg_n != 7'h7F) n_lit++;
         if (anode_n == 4'b0111) n_an++;
         if (i == 7) chk_out("bright3_last_lit", 4'b0111, 7'h06, 1'b1, 1'b0);
         if (i == 8) chk_out("bright3_first_dark", 4'b0111, 7'h7F, 1'b1, 1'b0);
      end
      chk("bright3_lit_cycles", 16'(n_lit), 16'd8);
      chk("bright3_anode_cycles", 16'(n_an), 16'd16);
      bus.brightness = 3'd7;

      // enable drop during digit 2, then re-enable
      goto(450); bus.enable = 1'b0;
      goto(451); chk_out("disable_dark", 4'hF, 7'h7F, 1'b1, 1'b0);
      goto(455); bus.enable = 1'b1;
      goto(459); chk_out("reenable_blank", 4'hF, 7'h7F, 1'b1, 1'b0);
      goto(460); chk_out("reenable_d0", 4'b1110, 7'h24, 1'b1, 1'b0);

      // async reset mid-ON
      goto(465); chk_out("pre_reset_on", 4'b1110, 7'h24, 1'b1, 1'b0);
      #1 reset = 1'b0;
      #1 chk_out("reset_mid_on", 4'hF, 7'h7F, 1'b1, 1'b0);
      #1 reset = 1'b1;
      goto(469); chk_out("post_reset_blank", 4'hF, 7'h7F, 1'b1, 1'b0);
      goto(470); chk_out("post_reset_d0", 4'b1110, 7'h40, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
